ru_write_arbiter: RTL and testbench
===================================

// Module: ru_write_arbiter
// PURPOSE
//  Shares the single write port of registers_unit (rd/dataWr/ruWr) between two writeback sources.
//  Source A: in-order pipeline WB stage. It cannot be back-pressured except through pipe_stall.
//  Source B: long-latency unit (load/mul-div return) using a valid/ready handshake.
//  Sits between the WB stage and registers_unit. Has a starvation guard and same-rd ordering protection.
// PARAMETERS
//  XLEN      32  data width of register file
//  REGW      5   register index width
//  MAX_WAIT  4   max consecutive cycles B may be denied while valid (>=1)
// PORTS
//  clk         in   1     clock, all flops on posedge
//  rst_n       in   1     asynchronous active-low reset
//  a_valid     in   1     pipeline WB has a result this cycle
//  a_rd        in   REGW  pipeline destination register
//  a_data      in   XLEN  pipeline result
//  b_valid     in   1     long-latency unit has a result; held stable until b_ready
//  b_rd        in   REGW  long-latency destination register
//  b_data      in   XLEN  long-latency result
//  b_ready     out  1     B transaction accepted this cycle (combinational)
//  pipe_stall  out  1     A not accepted this cycle; pipeline must hold WB (combinational)
//  rd          out  REGW  to registers_unit.rd (registered)
//  dataWr      out  XLEN  to registers_unit.dataWr (registered)
//  ruWr        out  1     to registers_unit.ruWr (registered)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - rd=0, dataWr=0, ruWr=0, wait_cnt=0, state=NORMAL.
//   - b_ready=0 and pipe_stall=0 while in reset.
//   - A registered write not yet issued is dropped. B is not consumed and must stay held.
//  State machine, derived from wait_cnt (width clog2(MAX_WAIT+1)):
//   - NORMAL:  wait_cnt < MAX_WAIT.
//   - STARVED: wait_cnt == MAX_WAIT.
//  Grant, per cycle (combinational):
//   - same = a_valid & b_valid & (a_rd==b_rd) & (a_rd!=0)
//   - grant_b = b_valid & (!a_valid | STARVED | same)
//   - grant_a = a_valid & !grant_b
//   - b_ready = grant_b
//   - pipe_stall = a_valid & grant_b
//  Ordering rule: on a same-rd collision B (older instruction) writes first, then A on the next cycle.
//   The younger value therefore wins in the register file.
//  Write issue, registered, 1-cycle latency from grant to ruWr:
//   - ruWr <= (grant_a & a_rd!=0) | (grant_b & b_rd!=0)
//   - rd/dataWr <= fields of the granted source.
//   - rd/dataWr hold their previous value when nothing is granted.
//   - Writes to x0 are consumed (grant, handshake) but ruWr=0; x0 is never written.
//   - registers_unit commits the value on the posedge after ruWr is seen.
//   - Downstream bypass logic reads the in-flight write from rd/dataWr/ruWr.
//  wait_cnt:
//   - Clears when grant_b or !b_valid.
//   - Otherwise increments, saturating at MAX_WAIT.
//   - At most MAX_WAIT consecutive denials of B, and at most 1 stall cycle per B grant.
//  Simultaneous events:
//   - A alone: granted, no stall.
//   - B alone: granted the same cycle, wait_cnt stays 0.
//   - Both valid, different rd, NORMAL: A wins and wait_cnt increments.
//   - A never starves: after each B grant in STARVED, wait_cnt=0, so A wins for the next MAX_WAIT cycles.
//  Invariants: grant_a & grant_b never both 1; at most one RU write per cycle.
// TESTING
//  1. Run traffic, pull rst_n low mid-cycle -> ruWr/rd/dataWr=0 immediately; b_ready=0, pipe_stall=0; B held then accepted after release.
//  2. a_valid, a_rd=1, a_data=0x12345678 -> next cycle ruWr=1, rd=1, dataWr=0x12345678; later read of rs1=1 gives 0x12345678.
//  3. A valid every cycle (rd=4), B valid rd=2 data 0x87654321, MAX_WAIT=4 -> A wins 4 cycles; 5th cycle b_ready=1, pipe_stall=1; next cycle rd=2, dataWr=0x87654321.
//  4. a_rd=b_rd=3, b_data=0xAAAA0000, a_data=0x5555FFFF -> B first with 1 stall cycle, then A; x3 ends at 0x5555FFFF.
//  5. a_rd=0 with a_valid -> no stall, ruWr stays 0; x0 still reads 0.
//  6. B alone with rd=7 -> b_ready same cycle, ruWr next cycle; wait_cnt remains 0 (check via no spurious stall afterwards).

Source files
------------

// File: rtl/ru_write_arbiter.sv
// ru_write_arbiter
//   Shares the single registers_unit write port between two writeback sources:
//     A - in-order pipeline WB stage (only back-pressure is pipe_stall)
//     B - long-latency unit (load / mul-div return) with a valid/ready handshake
//   B is favoured when A is idle, when B has been denied MAX_WAIT cycles in a row,
//   or when both target the same non-zero register (B is the older instruction,
//   so it writes first and the younger A value lands last).
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   a_valid, a_rd, a_data    pipeline writeback request
//   b_valid, b_rd, b_data    long-latency writeback request (held until b_ready)
//   b_ready                  B accepted this cycle (combinational)
//   pipe_stall               A not accepted this cycle (combinational)
//   rd, dataWr, ruWr         registered write port towards registers_unit
module ru_write_arbiter #(
  parameter int XLEN     = 32,
  parameter int REGW     = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  input  logic [REGW-1:0] a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  input  logic [REGW-1:0] b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  output logic            pipe_stall,
  output logic [REGW-1:0] rd,
  output logic [XLEN-1:0] dataWr,
  output logic            ruWr
);

  localparam int CNTW = $clog2(MAX_WAIT + 1);
  localparam logic [CNTW-1:0] WAIT_LIMIT = CNTW'(MAX_WAIT);

  typedef enum logic {
    NORMAL  = 1'b0,
    STARVED = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [CNTW-1:0] waitCnt_reg, waitCnt_next;
  logic            sameRd;
  logic            grantA;
  logic            grantB;

  always_comb begin
    // Same non-zero destination: the older B result must land before A's.
    sameRd = a_valid & b_valid & (a_rd == b_rd) & (a_rd != '0);
    // Gating with rst_n keeps both handshake outputs low while reset is held,
    // so B is not consumed and the pipeline is not stalled during reset.
    grantB = rst_n & b_valid & (~a_valid | (state_reg == STARVED) | sameRd);
    grantA = rst_n & a_valid & ~grantB;

    b_ready    = grantB;
    pipe_stall = a_valid & grantB;

    // Consecutive-denial counter for B; saturates at the limit, which is
    // exactly the STARVED condition.
    waitCnt_next = waitCnt_reg;
    if (grantB | ~b_valid) begin
      waitCnt_next = '0;
    end else if (waitCnt_reg != WAIT_LIMIT) begin
      waitCnt_next = waitCnt_reg + CNTW'(1);
    end

    state_next = (waitCnt_next == WAIT_LIMIT) ? STARVED : NORMAL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= NORMAL;
      waitCnt_reg <= '0;
      ruWr        <= 1'b0;
      rd          <= '0;
      dataWr      <= '0;
    end else begin
      state_reg   <= state_next;
      waitCnt_reg <= waitCnt_next;
      // x0 writes are still granted (handshake completes) but never issued.
      ruWr        <= (grantA & (a_rd != '0)) | (grantB & (b_rd != '0));
      // rd/dataWr hold when nothing is granted so bypass logic sees stable data.
      if (grantB) begin
        rd     <= b_rd;
        dataWr <= b_data;
      end else if (grantA) begin
        rd     <= a_rd;
        dataWr <= a_data;
      end
    end
  end

endmodule

// File: tb/tb_ru_write_arbiter.sv
module tb_ru_write_arbiter;

  localparam int XLEN     = 32;
  localparam int REGW     = 5;
  localparam int MAX_WAIT = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            a_valid;
  logic [REGW-1:0] a_rd;
  logic [XLEN-1:0] a_data;
  logic            b_valid;
  logic [REGW-1:0] b_rd;
  logic [XLEN-1:0] b_data;
  logic            b_ready;
  logic            pipe_stall;
  logic [REGW-1:0] rd;
  logic [XLEN-1:0] dataWr;
  logic            ruWr;

  ru_write_arbiter #(.XLEN(XLEN), .REGW(REGW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data),
    .b_ready(b_ready), .pipe_stall(pipe_stall),
    .rd(rd), .dataWr(dataWr), .ruWr(ruWr)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;

  // Register file contents as committed from the DUT's write port, and as
  // predicted by the reference model during the random phase.
  logic [XLEN-1:0] rfSeen [32];
  logic [XLEN-1:0] rfExp  [32];

  // Each write lasts exactly one cycle, so sampling mid-cycle sees it once.
  always @(negedge clk) begin
    if (rst_n && ruWr) rfSeen[rd] = dataWr;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [REGW-1:0] ard, input logic [XLEN-1:0] ad,
                       input logic bv, input logic [REGW-1:0] brd, input logic [XLEN-1:0] bd);
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
  endtask

  typedef struct {
    logic            av;
    logic [REGW-1:0] ard;
    logic [XLEN-1:0] ad;
    logic            bv;
    logic [REGW-1:0] brd;
    logic [XLEN-1:0] bd;
    logic            eBReady;
    logic            eStall;
    logic            eRuWr;   // registered outputs seen this cycle (from previous grant)
    logic [REGW-1:0] eRd;
    logic [XLEN-1:0] eData;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [REGW-1:0] ard, input logic [XLEN-1:0] ad,
                              input logic bv, input logic [REGW-1:0] brd, input logic [XLEN-1:0] bd,
                              input logic eb, input logic es, input logic er,
                              input logic [REGW-1:0] erd, input logic [XLEN-1:0] ed);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.bv = bv; v.brd = brd; v.bd = bd;
    v.eBReady = eb; v.eStall = es; v.eRuWr = er; v.eRd = erd; v.eData = ed;
    return v;
  endfunction

  vec_t vecs [15];

  // Reference model state for the random phase
  int              mDenied;
  logic            expRuWr;
  logic [REGW-1:0] expRd;
  logic [XLEN-1:0] expData;

  initial begin
    logic            av, bv, aHold, bHold, starved, collide, gA, gB;
    logic [REGW-1:0] ard, brd;
    logic [XLEN-1:0] ad, bd;

    for (int i = 0; i < 32; i++) begin rfSeen[i] = '0; rfExp[i] = '0; end
    drive(1'b0, '0, '0, 1'b0, '0, '0);

    // Directed table: starts straight out of reset.
    vecs[0]  = mk(1, 1, 32'h12345678, 0, 0, 0,            0, 0, 0, 0, 32'h0);
    vecs[1]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 1, 1, 32'h12345678);
    vecs[2]  = mk(1, 4, 32'h44,       1, 2, 32'h87654321, 0, 0, 0, 1, 32'h12345678);
    vecs[3]  = mk(1, 4, 32'h44,       1, 2, 32'h87654321, 0, 0, 1, 4, 32'h44);
    vecs[4]  = mk(1, 4, 32'h44,       1, 2, 32'h87654321, 0, 0, 1, 4, 32'h44);
    vecs[5]  = mk(1, 4, 32'h44,       1, 2, 32'h87654321, 0, 0, 1, 4, 32'h44);
    vecs[6]  = mk(1, 4, 32'h45,       1, 2, 32'h87654321, 1, 1, 1, 4, 32'h44);
    vecs[7]  = mk(1, 4, 32'h45,       0, 0, 0,            0, 0, 1, 2, 32'h87654321);
    vecs[8]  = mk(1, 3, 32'h5555FFFF, 1, 3, 32'hAAAA0000, 1, 1, 1, 4, 32'h45);
    vecs[9]  = mk(1, 3, 32'h5555FFFF, 0, 0, 0,            0, 0, 1, 3, 32'hAAAA0000);
    vecs[10] = mk(1, 0, 32'hDEAD,     0, 0, 0,            0, 0, 1, 3, 32'h5555FFFF);
    vecs[11] = mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 32'hDEAD);
    vecs[12] = mk(0, 0, 0,            1, 7, 32'h77,       1, 0, 0, 0, 32'hDEAD);
    vecs[13] = mk(1, 5, 32'h55,       1, 6, 32'h66,       0, 0, 1, 7, 32'h77);
    vecs[14] = mk(0, 0, 0,            0, 0, 0,            0, 0, 1, 5, 32'h55);

    // Reset held: handshake outputs must be low even with requests present.
    repeat (2) @(negedge clk);
    drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd9, 32'h9);
    #1;
    check("reset_b_ready", b_ready, 0);
    check("reset_pipe_stall", pipe_stall, 0);
    check("reset_ruWr", ruWr, 0);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].bv, vecs[i].brd, vecs[i].bd);
      #1;
      $display("vec %0d: a=%b/x%0d b=%b/x%0d -> b_ready=%b pipe_stall=%b ruWr=%b rd=%0d dataWr=%h",
               i, a_valid, a_rd, b_valid, b_rd, b_ready, pipe_stall, ruWr, rd, dataWr);
      check($sformatf("vec%0d_b_ready", i), b_ready, vecs[i].eBReady);
      check($sformatf("vec%0d_pipe_stall", i), pipe_stall, vecs[i].eStall);
      check($sformatf("vec%0d_ruWr", i), ruWr, vecs[i].eRuWr);
      check($sformatf("vec%0d_rd", i), rd, vecs[i].eRd);
      check($sformatf("vec%0d_dataWr", i), dataWr, vecs[i].eData);
    end

    // Mid-cycle asynchronous reset with traffic present, B held through reset.
    @(negedge clk);
    drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset asserted: ruWr=%b rd=%0d dataWr=%h b_ready=%b pipe_stall=%b",
             ruWr, rd, dataWr, b_ready, pipe_stall);
    check("areset_ruWr", ruWr, 0);
    check("areset_rd", rd, 0);
    check("areset_dataWr", dataWr, 0);
    check("areset_b_ready", b_ready, 0);
    check("areset_pipe_stall", pipe_stall, 0);
    repeat (2) @(negedge clk);
    drive(1'b0, '0, '0, 1'b1, 5'd9, 32'h99);
    rst_n = 1'b1;
    #1;
    $display("reset released: held B x9 -> b_ready=%b pipe_stall=%b", b_ready, pipe_stall);
    check("post_reset_b_ready", b_ready, 1);
    check("post_reset_pipe_stall", pipe_stall, 0);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    check("post_reset_ruWr", ruWr, 1);
    check("post_reset_rd", rd, 9);
    check("post_reset_dataWr", dataWr, 32'h99);
    @(negedge clk);
    #1;
    check("rf_x0", rfSeen[0], 0);
    check("rf_x1", rfSeen[1], 32'h12345678);
    check("rf_x2", rfSeen[2], 32'h87654321);
    check("rf_x3", rfSeen[3], 32'h5555FFFF);
    check("rf_x7", rfSeen[7], 32'h77);
    check("rf_x8_dropped", rfSeen[8], 0);
    check("rf_x9", rfSeen[9], 32'h99);

    // Random phase against the reference model, from a fresh reset.
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin rfSeen[i] = '0; rfExp[i] = '0; end
    @(negedge clk);
    rst_n = 1'b1;
    mDenied = 0; expRuWr = 0; expRd = '0; expData = '0;
    aHold = 0; bHold = 0;
    av = 0; bv = 0; ard = '0; brd = '0; ad = '0; bd = '0;

    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      // A stalled by the arbiter and B not yet accepted both keep their payloads.
      if (!aHold) begin
        av  = ($urandom_range(0, 3) != 0);
        ard = REGW'($urandom_range(0, 3));
        ad  = $urandom;
      end
      if (!bHold) begin
        bv  = ($urandom_range(0, 2) == 0);
        brd = REGW'($urandom_range(0, 3));
        bd  = $urandom;
      end
      drive(av, ard, ad, bv, brd, bd);
      #1;

      starved = (mDenied >= MAX_WAIT);
      collide = av && bv && (ard == brd) && (ard != 0);
      gB = bv && (!av || starved || collide);
      gA = av && !gB;

      $display("rnd %0d: a=%b/x%0d b=%b/x%0d denied=%0d -> b_ready=%b pipe_stall=%b ruWr=%b rd=%0d",
               cyc, av, ard, bv, brd, mDenied, b_ready, pipe_stall, ruWr, rd);
      check("rnd_b_ready", b_ready, gB);
      check("rnd_pipe_stall", pipe_stall, av && gB);
      check("rnd_ruWr", ruWr, expRuWr);
      check("rnd_rd", rd, expRd);
      check("rnd_dataWr", dataWr, expData);

      if (gB) begin
        expRuWr = (brd != 0); expRd = brd; expData = bd;
      end else if (gA) begin
        expRuWr = (ard != 0); expRd = ard; expData = ad;
      end else begin
        expRuWr = 0;
      end
      if (expRuWr) rfExp[expRd] = expData;

      mDenied = (bv && !gB) ? ((mDenied < MAX_WAIT) ? mDenied + 1 : MAX_WAIT) : 0;
      aHold = av && !gA;
      bHold = bv && !gB;
    end

    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    check("rnd_final_ruWr", ruWr, expRuWr);
    check("rnd_final_rd", rd, expRd);
    @(negedge clk);
    #1;
    for (int r = 0; r < 4; r++) begin
      check($sformatf("rnd_rf_x%0d", r), rfSeen[r], rfExp[r]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
